// File: rtl/bf_pair_buffer_01.sv
// Stage-01 pairing buffer: drives the upstream add/sub selector, delays each accepted
// 16-lane R/Q beat by DELAY beats and emits (beat n, beat n+DELAY) operand pairs.
module bf_pair_buffer_01 #(
    parameter int WIDTH = 10,
    parameter int LANES = 16,
    parameter int DELAY = 8,
    parameter int FRAME = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_R_01 [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_Q_01 [0:LANES-1],
    output logic                    mux_sel,
    output logic                    dout_valid,
    output logic                    dout_last,
    output logic signed [WIDTH-1:0] dout_R_a [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_Q_a [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_R_b [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_Q_b [0:LANES-1]
);

    localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int PB = $clog2(DELAY);

    // Handshake: din_valid alone qualifies a beat; there is no ready, so every beat with
    // din_valid=1 is taken on the rising edge. dout_valid is a one-cycle pulse, never stalled.

    logic [CW-1:0]           beat_cnt;
    logic                    phase;
    logic                    pair_beat;
    logic signed [WIDTH-1:0] dl_R [0:DELAY-1][0:LANES-1];
    logic signed [WIDTH-1:0] dl_Q [0:DELAY-1][0:LANES-1];

    assign phase     = beat_cnt[PB];
    assign pair_beat = din_valid & phase;
    // Taken straight from the counter flop so it always describes the next beat to arrive.
    assign mux_sel   = beat_cnt[CW-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (din_valid) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < DELAY; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    dl_R[s][l] <= '0;
                    dl_Q[s][l] <= '0;
                end
            end
        end else if (din_valid) begin
            for (int l = 0; l < LANES; l++) begin
                dl_R[0][l] <= din_R_01[l];
                dl_Q[0][l] <= din_Q_01[l];
            end
            for (int s = 1; s < DELAY; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    dl_R[s][l] <= dl_R[s-1][l];
                    dl_Q[s][l] <= dl_Q[s-1][l];
                end
            end
        end
    end

    // The delay-line tail is exactly DELAY accepted beats older than the current din.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                dout_R_a[l] <= '0;
                dout_Q_a[l] <= '0;
                dout_R_b[l] <= '0;
                dout_Q_b[l] <= '0;
            end
        end else if (pair_beat) begin
            dout_valid <= 1'b1;
            dout_last  <= (beat_cnt == CW'(FRAME - 1));
            for (int l = 0; l < LANES; l++) begin
                dout_R_a[l] <= dl_R[DELAY-1][l];
                dout_Q_a[l] <= dl_Q[DELAY-1][l];
                dout_R_b[l] <= din_R_01[l];
                dout_Q_b[l] <= din_Q_01[l];
            end
        end else begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf_pair_buffer_01.sv
// Directed bench for bf_pair_buffer_01: continuous, back-to-back, gapped, extreme-value
// and mid-frame-reset streams, each pair checked against hand-derived beat pairings.
module tb_bf_pair_buffer_01;

    localparam int W = 10;
    localparam int L = 16;
    localparam int D = 8;
    localparam int F = 32;

    logic                clk;
    logic                rstn;
    logic                din_valid;
    logic signed [W-1:0] din_R_01 [0:L-1];
    logic signed [W-1:0] din_Q_01 [0:L-1];
    logic                mux_sel;
    logic                dout_valid;
    logic                dout_last;
    logic signed [W-1:0] dout_R_a [0:L-1];
    logic signed [W-1:0] dout_Q_a [0:L-1];
    logic signed [W-1:0] dout_R_b [0:L-1];
    logic signed [W-1:0] dout_Q_b [0:L-1];

    typedef struct {
        int a;
        int b;
        int last;
        int mode;
        int cyc;
    } pair_t;

    pair_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    bf_pair_buffer_01 #(.WIDTH(W), .LANES(L), .DELAY(D), .FRAME(F)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_R_01  (din_R_01),
        .din_Q_01  (din_Q_01),
        .mux_sel   (mux_sel),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .dout_R_a  (dout_R_a),
        .dout_Q_a  (dout_Q_a),
        .dout_R_b  (dout_R_b),
        .dout_Q_b  (dout_Q_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // mode 0: R=k, Q=-k; mode 1: alternating +511/-512; mode 2: R=100+k, Q=-(100+k)
    function automatic int lane_val(input int mode, input int k, input int lane, input bit is_q);
        int v;
        case (mode)
            1:       v = ((k + lane) % 2 == 1) ? -512 : 511;
            2:       v = 100 + k;
            default: v = k;
        endcase
        if (mode == 1) return is_q ? ((v == 511) ? -512 : 511) : v;
        return is_q ? -v : v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int mode, input int k);
        @(posedge clk);
        #1;
        check("mux_sel", int'(mux_sel), ((k % F) >= F/2) ? 1 : 0);
        for (int l = 0; l < L; l++) begin
            din_R_01[l] = W'(lane_val(mode, k, l, 1'b0));
            din_Q_01[l] = W'(lane_val(mode, k, l, 1'b1));
        end
        din_valid = 1'b1;
        if (((k % F) / D) % 2 == 1)
            exp_q.push_back('{a: k - D, b: k, last: ((k % F) == F - 1) ? 1 : 0, mode: mode, cyc: cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz;
        nz = 0;
        for (int l = 0; l < L; l++)
            if (dout_R_a[l] != 0 || dout_Q_a[l] != 0 || dout_R_b[l] != 0 || dout_Q_b[l] != 0) nz++;
        check({tag, "_lanes_nonzero"}, nz, 0);
        check({tag, "_dout_valid"}, int'(dout_valid), 0);
        check({tag, "_dout_last"}, int'(dout_last), 0);
        check({tag, "_mux_sel"}, int'(mux_sel), 0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rstn && dout_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_dout_valid", 1, 0);
            end else begin
                pair_t p;
                int    err;
                p = exp_q.pop_front();
                check("pair_cycle", cyc, p.cyc);
                check("pair_last", int'(dout_last), p.last);
                err = 0;
                for (int l = 0; l < L; l++) begin
                    if (int'(dout_R_a[l]) != lane_val(p.mode, p.a, l, 1'b0)) err++;
                    if (int'(dout_Q_a[l]) != lane_val(p.mode, p.a, l, 1'b1)) err++;
                    if (int'(dout_R_b[l]) != lane_val(p.mode, p.b, l, 1'b0)) err++;
                    if (int'(dout_Q_b[l]) != lane_val(p.mode, p.b, l, 1'b1)) err++;
                end
                check($sformatf("pair_lanes_b%0d", p.b), err, 0);
                check("pair_a_R0", int'(dout_R_a[0]), lane_val(p.mode, p.a, 0, 1'b0));
                check("pair_b_Q15", int'(dout_Q_b[L-1]), lane_val(p.mode, p.b, L-1, 1'b1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn      = 1'b0;
        din_valid = 1'b0;
        for (int l = 0; l < L; l++) begin
            din_R_01[l] = '0;
            din_Q_01[l] = '0;
        end
        #12;
        check_reset_outputs("init");
        @(negedge clk);
        rstn = 1'b1;

        // three back-to-back frames, continuous
        for (int k = 0; k < 3 * F; k++) send(0, k);
        idle(3);

        // gapped frame: three idle cycles after every beat
        for (int k = 0; k < F; k++) begin
            send(0, k);
            idle(3);
        end
        idle(2);

        // extreme values
        for (int k = 0; k < F; k++) send(1, k);
        idle(3);

        // partial frame up to beat 12, then asynchronous reset between edges
        for (int k = 0; k <= 12; k++) send(0, k);
        idle(2);
        check("pre_reset_data_nonzero", (dout_R_b[0] != 0) ? 1 : 0, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < F; k++) send(2, k);
        idle(4);

        check("pending_pairs", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
